// File: rtl/tiny_soc_mem_adapter_pkg.sv
// Shared types and helpers for the Ibex data-port to SRAM adapter.
package tiny_soc_mem_pkg;

    // Fibonacci feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LfsrTaps = 16'hB400;

    // One slot of the fixed-latency response pipeline
    typedef struct packed {
        logic        valid;
        logic        err;
        logic        we;
        logic [31:0] data;
    } resp_stage_t;

    // Expand byte enables into a per-bit write mask
    function automatic logic [31:0] be_to_strb(input logic [3:0] be);
        logic [31:0] strb;
        strb = '0;
        for (int i = 0; i < 4; i++) begin
            strb[i*8 +: 8] = {8{be[i]}};
        end
        return strb;
    endfunction

endpackage

// File: rtl/tiny_soc_mem_adapter_if.sv
// Core-side req/gnt/rvalid data bus of the Ibex LSU.
interface tiny_soc_mem_adapter_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/tiny_soc_mem_adapter_lfsr16.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random grant stalls.
module tiny_soc_lfsr16
    import tiny_soc_mem_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    // Shift left, feeding the XOR of the tapped bits into bit 0
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {state_q[14:0], ^(state_q & LfsrTaps)};
        end
    end

    // State register, reloads the seed on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/tiny_soc_mem_adapter.sv
// Adapter between the Ibex data port and the single-cycle SRAM: real grants
// with optional random stalls, an outstanding-request cap, fixed-latency
// in-order responses and bus errors for accesses outside the SRAM window.
module tiny_soc_mem_adapter
    import tiny_soc_mem_pkg::*;
#(
    parameter logic [31:0] AddrBase       = 32'h8000_0000,
    parameter int          MemDepth       = 1 << 20,
    parameter int          Latency        = 2,
    parameter int          MaxOutstanding = 2,
    parameter bit          StallEn        = 1'b1,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    tiny_soc_mem_adapter_if.slave       bus,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [$clog2(MemDepth)-1:0] mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    output logic [31:0]                 mem_strb_o,
    input  logic [31:0]                 mem_rdata_i
);

    localparam int AW   = $clog2(MemDepth);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW:0] MaxOut = MaxOutstanding[CntW:0];

    logic [15:0]     lfsr;
    logic            stall;
    logic [31:0]     offset;
    logic            in_range;
    logic            slot_free;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;
    logic [CntW-1:0] cnt_q, cnt_d;
    resp_stage_t     pipe_q [Latency];
    resp_stage_t     pipe_d [Latency];
    resp_stage_t     out_stage;
    logic            unused_lfsr;

    tiny_soc_lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];
    assign stall       = StallEn & lfsr[0];

    // Addresses below the base wrap to huge offsets and fall out of range
    assign offset   = bus.addr - AddrBase;
    assign in_range = {1'b0, offset} < (33'(MemDepth) << 2);

    // A response leaving this cycle frees its slot for a same-cycle grant
    assign slot_free = {1'b0, cnt_q} < (MaxOut + {{CntW{1'b0}}, rvalid});
    assign gnt       = rst_ni & bus.req & ~stall & slot_free;

    assign mem_req_o   = gnt & in_range;
    assign mem_we_o    = mem_req_o & bus.we;
    assign mem_addr_o  = offset[AW+1:2];
    assign mem_wdata_o = bus.wdata;
    assign mem_strb_o  = be_to_strb(bus.be);

    // Outstanding count: up on grant, down on response
    always_comb begin
        cnt_d = cnt_q;
        case ({gnt, rvalid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next pipeline contents; read data joins the slot one cycle after grant
    always_comb begin
        pipe_d[0] = '{valid: gnt, err: gnt & ~in_range, we: bus.we, data: 32'h0};
        for (int i = 1; i < Latency; i++) begin
            pipe_d[i] = pipe_q[i-1];
            if (i == 1 && pipe_q[0].valid && !pipe_q[0].err && !pipe_q[0].we) begin
                pipe_d[i].data = mem_rdata_i;
            end
        end
    end

    // Counter and response pipeline registers; reset drops in-flight responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            pipe_q <= pipe_d;
        end
    end

    assign out_stage = pipe_q[Latency-1];
    assign rvalid    = out_stage.valid;

    // With a single stage the SRAM data is still in flight, so pass it through
    always_comb begin
        rdata = out_stage.data;
        if (Latency == 1 && out_stage.valid && !out_stage.err && !out_stage.we) begin
            rdata = mem_rdata_i;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.err    = out_stage.valid & out_stage.err;
    assign bus.rdata  = rdata;

    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        {1'b0, cnt_q} <= MaxOut);
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid && cnt_q == '0));

endmodule

// File: tb/tb_tiny_soc_mem_adapter.sv
// Directed bench for the Ibex data-port adapter: three configurations
// (plain Latency=2, Latency=3 limit, stalling Latency=2).
module tb_tiny_soc_mem_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tiny_soc_mem_adapter_if ifa ();
    tiny_soc_mem_adapter_if ifb ();
    tiny_soc_mem_adapter_if ifc ();

    logic        a_mreq, a_mwe, b_mreq, b_mwe, c_mreq, c_mwe;
    logic [19:0] a_maddr, b_maddr, c_maddr;
    logic [31:0] a_mwdata, a_mstrb, b_mwdata, b_mstrb, c_mwdata, c_mstrb;
    logic [31:0] a_mrdata = 32'h0, b_mrdata = 32'h0, c_mrdata = 32'h0;

    tiny_soc_mem_adapter #(.Latency(2), .MaxOutstanding(2), .StallEn(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa),
        .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
        .mem_wdata_o(a_mwdata), .mem_strb_o(a_mstrb), .mem_rdata_i(a_mrdata));

    tiny_soc_mem_adapter #(.Latency(3), .MaxOutstanding(2), .StallEn(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb),
        .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
        .mem_wdata_o(b_mwdata), .mem_strb_o(b_mstrb), .mem_rdata_i(b_mrdata));

    tiny_soc_mem_adapter #(.Latency(2), .MaxOutstanding(2), .StallEn(1'b1),
                           .LfsrSeed(16'hACE1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc),
        .mem_req_o(c_mreq), .mem_we_o(c_mwe), .mem_addr_o(c_maddr),
        .mem_wdata_o(c_mwdata), .mem_strb_o(c_mstrb), .mem_rdata_i(c_mrdata));

    // SRAM for dut_a: 256 aliased words, preloaded for the directed tests
    logic [31:0] sram_a [256] = '{1: 32'hFFFF_FFFF, 16: 32'hDEAD_BEEF, default: 32'h0};
    always @(posedge clk) begin
        if (a_mreq) begin
            if (a_mwe) sram_a[a_maddr[7:0]] <= (sram_a[a_maddr[7:0]] & ~a_mstrb) | (a_mwdata & a_mstrb);
            else       a_mrdata <= sram_a[a_maddr[7:0]];
        end
    end

    // Read-only pattern SRAMs for dut_b and dut_c
    always @(posedge clk) if (b_mreq) b_mrdata <= 32'hB000_0000 | 32'(b_maddr);
    always @(posedge clk) if (c_mreq) c_mrdata <= 32'hC0DE_0000 ^ 32'(c_maddr);

    // Reference LFSR, taps 16/14/13/11, for dut_c's stall pattern
    logic [15:0] lfsr_m = 16'hACE1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t q [$];

    task automatic test_reset();
        @(negedge clk);
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h8000_0000;
        ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h8000_0000;
        #1;
        checks++;
        if ({ifa.gnt, ifa.rvalid, ifa.err, a_mreq, a_mwe, ifa.rdata} !== 37'h0) begin
            failures++;
            $display("FAIL rst_a got=%h exp=0", {ifa.gnt, ifa.rvalid, ifa.err, a_mreq, a_mwe, ifa.rdata});
        end
        checks++;
        if ({ifc.gnt, ifc.rvalid, ifc.err, c_mreq, c_mwe, ifc.rdata} !== 37'h0) begin
            failures++;
            $display("FAIL rst_c got=%h exp=0", {ifc.gnt, ifc.rvalid, ifc.err, c_mreq, c_mwe, ifc.rdata});
        end
        ifa.req = 1'b0; ifc.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({ifa.rvalid, ifb.rvalid, ifc.rvalid} !== 3'b000) begin
            failures++;
            $display("FAIL rst_rel_rvalid got=%b exp=000", {ifa.rvalid, ifb.rvalid, ifc.rvalid});
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ifa.req = 1'b1; ifa.addr = 32'h8000_0040; ifa.we = 1'b0; ifa.be = 4'hF;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq, a_mwe, a_maddr} !== {3'b110, 20'h00010}) begin
            failures++;
            $display("FAIL sr_grant got=%h exp=%h", {ifa.gnt, a_mreq, a_mwe, a_maddr}, {3'b110, 20'h00010});
        end
        @(negedge clk);
        ifa.req = 1'b0;
        #1;
        checks++;
        if (ifa.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL sr_early_rvalid got=%b exp=0", ifa.rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ifa.rvalid, ifa.err, ifa.rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL sr_resp got=%h exp=%h", {ifa.rvalid, ifa.err, ifa.rdata}, {2'b10, 32'hDEAD_BEEF});
        end
        @(negedge clk);
        #1;
        checks++;
        if (ifa.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL sr_late_rvalid got=%b exp=0", ifa.rvalid);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h8000_0004;
        ifa.be = 4'b0011; ifa.wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq, a_mwe, a_maddr, a_mstrb, a_mwdata} !==
            {3'b111, 20'h00001, 32'h0000_FFFF, 32'h1234_5678}) begin
            failures++;
            $display("FAIL wr_drive got=%h exp=%h", {ifa.gnt, a_mreq, a_mwe, a_maddr, a_mstrb, a_mwdata},
                     {3'b111, 20'h00001, 32'h0000_FFFF, 32'h1234_5678});
        end
        @(negedge clk);
        ifa.we = 1'b0; ifa.be = 4'hF;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq, a_mwe} !== 3'b110) begin
            failures++;
            $display("FAIL wr_rd_grant got=%b exp=110", {ifa.gnt, a_mreq, a_mwe});
        end
        @(negedge clk);
        ifa.req = 1'b0;
        #1;
        checks++;
        if ({ifa.rvalid, ifa.err, ifa.rdata} !== {2'b10, 32'h0}) begin
            failures++;
            $display("FAIL wr_resp got=%h exp=%h", {ifa.rvalid, ifa.err, ifa.rdata}, {2'b10, 32'h0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ifa.rvalid, ifa.err, ifa.rdata} !== {2'b10, 32'hFFFF_5678}) begin
            failures++;
            $display("FAIL wr_readback got=%h exp=%h", {ifa.rvalid, ifa.err, ifa.rdata}, {2'b10, 32'hFFFF_5678});
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 32'h0000_1000;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq} !== 2'b10) begin
            failures++;
            $display("FAIL oor_low got=%b exp=10", {ifa.gnt, a_mreq});
        end
        @(negedge clk);
        ifa.addr = 32'h8040_0000;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq} !== 2'b10) begin
            failures++;
            $display("FAIL oor_high got=%b exp=10", {ifa.gnt, a_mreq});
        end
        @(negedge clk);
        ifa.addr = 32'h803F_FFFC;
        #1;
        checks++;
        if ({ifa.gnt, a_mreq, a_maddr, ifa.rvalid, ifa.err, ifa.rdata} !== {2'b11, 20'hFFFFF, 2'b11, 32'h0}) begin
            failures++;
            $display("FAIL oor_lastword got=%h exp=%h", {ifa.gnt, a_mreq, a_maddr, ifa.rvalid, ifa.err, ifa.rdata},
                     {2'b11, 20'hFFFFF, 2'b11, 32'h0});
        end
        @(negedge clk);
        ifa.req = 1'b0;
        #1;
        checks++;
        if ({ifa.rvalid, ifa.err, ifa.rdata} !== {2'b11, 32'h0}) begin
            failures++;
            $display("FAIL oor_err2 got=%h exp=%h", {ifa.rvalid, ifa.err, ifa.rdata}, {2'b11, 32'h0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ifa.rvalid, ifa.err, ifa.rdata} !== {2'b10, 32'h0}) begin
            failures++;
            $display("FAIL oor_lastword_resp got=%h exp=%h", {ifa.rvalid, ifa.err, ifa.rdata}, {2'b10, 32'h0});
        end
        @(negedge clk);
        #1;
        checks++;
        if (ifa.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL oor_idle got=%b exp=0", ifa.rvalid);
        end
    endtask

    // Latency=3, limit 2: grants 0,1,3,4,6 and responses 3,4,6,7,9
    task automatic test_outstanding();
        logic [11:0] gmask = 12'h05B;
        logic [11:0] rmask = 12'h2D8;
        int k = 0;
        int r = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ifb.req = (k < 5); ifb.we = 1'b0; ifb.be = 4'hF;
            ifb.addr = 32'h8000_0000 + 32'(4 * k);
            #1;
            checks++;
            if (ifb.gnt !== gmask[c]) begin
                failures++;
                $display("FAIL lim_gnt cyc=%0d got=%b exp=%b", c, ifb.gnt, gmask[c]);
            end
            checks++;
            if (ifb.rvalid !== rmask[c]) begin
                failures++;
                $display("FAIL lim_rvalid cyc=%0d got=%b exp=%b", c, ifb.rvalid, rmask[c]);
            end
            if (ifb.rvalid === 1'b1) begin
                checks++;
                if ({ifb.err, ifb.rdata} !== {1'b0, 32'hB000_0000 | 32'(r)}) begin
                    failures++;
                    $display("FAIL lim_data idx=%0d got=%h exp=%h", r, {ifb.err, ifb.rdata}, {1'b0, 32'hB000_0000 | 32'(r)});
                end
                r++;
            end
            if (ifb.gnt === 1'b1) k++;
        end
        ifb.req = 1'b0;
    endtask

    task automatic test_random_stalls();
        int grants = 0;
        int t = 0;
        int maxcnt = 0;
        bit active = 0;
        bit egnt, erv, inr;
        logic [31:0] es;
        logic [19:0] word;
        exp_t e;
        while ((grants < 1000 || q.size() != 0) && t < 20000) begin
            @(negedge clk);
            if (!active) begin
                ifc.req = 1'b0;
                if (grants < 1000 && $urandom_range(3) != 0) begin
                    active = 1;
                    ifc.req = 1'b1;
                    ifc.we = 1'($urandom_range(1));
                    ifc.be = 4'($urandom_range(15));
                    ifc.wdata = $urandom();
                    if ($urandom_range(7) == 0) ifc.addr = $urandom() & 32'h7FFF_FFFC;
                    else ifc.addr = 32'h8000_0000 + ($urandom() & 32'h003F_FFFC);
                end
            end
            #1;
            erv = (q.size() != 0) && (q[0].due == t);
            egnt = active && !lfsr_m[0] && ((q.size() - int'(erv)) < 2);
            checks++;
            if (ifc.gnt !== egnt) begin
                failures++;
                $display("FAIL rs_gnt t=%0d got=%b exp=%b", t, ifc.gnt, egnt);
            end
            checks++;
            if (ifc.rvalid !== erv) begin
                failures++;
                $display("FAIL rs_rvalid t=%0d got=%b exp=%b", t, ifc.rvalid, erv);
            end
            if (erv) begin
                checks++;
                if ({ifc.err, ifc.rdata} !== {q[0].err, q[0].data}) begin
                    failures++;
                    $display("FAIL rs_resp t=%0d got=%h exp=%h", t, {ifc.err, ifc.rdata}, {q[0].err, q[0].data});
                end
                void'(q.pop_front());
            end
            if (int'(dut_c.cnt_q) > maxcnt) maxcnt = int'(dut_c.cnt_q);
            if (egnt) begin
                inr = ifc.addr >= 32'h8000_0000 && ifc.addr < 32'h8040_0000;
                word = 20'((ifc.addr - 32'h8000_0000) >> 2);
                for (int j = 0; j < 4; j++) es[j*8 +: 8] = {8{ifc.be[j]}};
                checks++;
                if (inr && {c_mreq, c_mwe, c_maddr, c_mwdata, c_mstrb} !== {1'b1, ifc.we, word, ifc.wdata, es}) begin
                    failures++;
                    $display("FAIL rs_mem t=%0d got=%h exp=%h", t, {c_mreq, c_mwe, c_maddr, c_mwdata, c_mstrb},
                             {1'b1, ifc.we, word, ifc.wdata, es});
                end else if (!inr && c_mreq !== 1'b0) begin
                    failures++;
                    $display("FAIL rs_mem_oor t=%0d got=%b exp=0", t, c_mreq);
                end
                e.due = t + 2;
                e.err = !inr;
                e.data = (inr && !ifc.we) ? (32'hC0DE_0000 ^ 32'(word)) : 32'h0;
                q.push_back(e);
                grants++;
                active = 0;
            end
            t++;
        end
        ifc.req = 1'b0;
        checks++;
        if (grants != 1000 || q.size() != 0) begin
            failures++;
            $display("FAIL rs_done grants=%0d pending=%0d exp=1000/0", grants, q.size());
        end
        checks++;
        if (maxcnt > 2) begin
            failures++;
            $display("FAIL rs_maxcnt got=%0d exp<=2", maxcnt);
        end
    endtask

    task automatic test_reset_midflight();
        int g = 0;
        int n = 0;
        int first = -1;
        while (g < 2 && n < 100) begin
            @(negedge clk);
            ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h8000_0100;
            #1;
            if (ifc.gnt === 1'b1) g++;
            n++;
        end
        checks++;
        if (g != 2) begin
            failures++;
            $display("FAIL rm_two_grants got=%0d exp=2", g);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.gnt, ifc.rvalid, ifc.err, c_mreq, c_mwe, ifc.rdata} !== 37'h0) begin
            failures++;
            $display("FAIL rm_outputs got=%h exp=0", {ifc.gnt, ifc.rvalid, ifc.err, c_mreq, c_mwe, ifc.rdata});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ifc.gnt, ifc.rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL rm_hold got=%b exp=00", {ifc.gnt, ifc.rvalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Seed ACE1 -> 59C3 -> B387 -> 670F -> CE1E: first even state at cycle 4
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (first >= 0) ifc.req = 1'b0;
            #1;
            checks++;
            if (ifc.rvalid !== ((first >= 0) && (i == first + 2))) begin
                failures++;
                $display("FAIL rm_rvalid i=%0d got=%b exp=%b", i, ifc.rvalid, (first >= 0) && (i == first + 2));
            end
            if (first < 0 && ifc.gnt === 1'b1) first = i;
        end
        checks++;
        if (first != 4) begin
            failures++;
            $display("FAIL rm_first_grant got=%0d exp=4", first);
        end
    endtask

    initial begin
        ifa.req = 1'b0; ifa.addr = '0; ifa.we = 1'b0; ifa.be = 4'hF; ifa.wdata = '0;
        ifb.req = 1'b0; ifb.addr = '0; ifb.we = 1'b0; ifb.be = 4'hF; ifb.wdata = '0;
        ifc.req = 1'b0; ifc.addr = '0; ifc.we = 1'b0; ifc.be = 4'hF; ifc.wdata = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_out_of_range();
        test_outstanding();
        test_random_stalls();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
